// File: rtl/risc_pkg.sv
// Shared definitions for the risc control slice: instruction fields, opcodes,
// ALU encodings, FSM state encoding and the opcode class bundle.
package risc_pkg;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int DST_HI  = 11;
    localparam int DST_LO  = 9;
    localparam int SRCA_HI = 8;
    localparam int SRCA_LO = 6;
    localparam int SRCB_HI = 5;
    localparam int SRCB_LO = 3;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;

    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_LD   = 4'h8;
    localparam logic [3:0] OPC_ST   = 4'h9;
    localparam logic [3:0] OPC_JMP  = 4'hA;
    localparam logic [3:0] OPC_BZ   = 4'hB;
    localparam logic [3:0] OPC_HALT = 4'hF;

    // ALU opcodes 1..7 pass their low three bits straight through as alu_op.
    localparam logic [2:0] ALU_NONE = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_XOR  = 3'd5;
    localparam logic [2:0] ALU_SHL  = 3'd6;
    localparam logic [2:0] ALU_SHR  = 3'd7;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_HALT    = 3'd5
    } state_e;

    typedef struct packed {
        logic nop;
        logic alu;
        logic ld;
        logic st;
        logic jmp;
        logic bz;
        logic halt;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/risc_opdec.sv
// Combinational opcode classifier; exactly one class bit is set per opcode.
module risc_opdec
    import risc_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OPC_NOP:                                     cls.nop     = 1'b1;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7:    cls.alu     = 1'b1;
            OPC_LD:                                      cls.ld      = 1'b1;
            OPC_ST:                                      cls.st      = 1'b1;
            OPC_JMP:                                     cls.jmp     = 1'b1;
            OPC_BZ:                                      cls.bz      = 1'b1;
            OPC_HALT:                                    cls.halt    = 1'b1;
            default:                                     cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/risc_ctrl.sv
// Multi-cycle control FSM: fetch/decode/execute/mem/writeback sequencing,
// program counter, and registered control strobes for the datapath.
module risc_ctrl
    import risc_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_rd,
    output logic [PC_W-1:0] pc,
    input  logic [15:0]     instr,
    input  logic            instr_vld,
    input  logic            zero_flag,
    output logic [2:0]      opnda_addr,
    output logic [2:0]      opndb_addr,
    output logic [2:0]      dst,
    output logic [2:0]      alu_op,
    output logic            reg_wr_vld,
    output logic            load_op,
    output logic            dm_rd,
    output logic            dm_wr,
    output logic            halted,
    output logic            illegal,
    output state_e          state_dbg
);

    localparam logic [PC_W-1:0] PC_ONE = 1;

    state_e          state;
    logic [15:0]     ir;
    op_class_t       cls;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_imm;

    risc_opdec u_opdec (
        .opcode (ir[OPC_HI:OPC_LO]),
        .cls    (cls)
    );

    assign pc_inc    = pc + PC_ONE;
    assign pc_imm    = PC_W'(ir[IMM_HI:IMM_LO]);
    assign state_dbg = state;

    // Outputs are assigned alongside the state they belong to, so each one
    // is valid in the same cycle the FSM sits in the matching state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            imem_rd    <= 1'b1;
            opnda_addr <= '0;
            opndb_addr <= '0;
            dst        <= '0;
            alu_op     <= ALU_NONE;
            reg_wr_vld <= 1'b0;
            load_op    <= 1'b0;
            dm_rd      <= 1'b0;
            dm_wr      <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            reg_wr_vld <= 1'b0;
            load_op    <= 1'b0;
            dm_rd      <= 1'b0;
            dm_wr      <= 1'b0;
            illegal    <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (instr_vld) begin
                        ir         <= instr;
                        opnda_addr <= instr[SRCA_HI:SRCA_LO];
                        opndb_addr <= instr[SRCB_HI:SRCB_LO];
                        dst        <= instr[DST_HI:DST_LO];
                        imem_rd    <= 1'b0;
                        state      <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    alu_op <= cls.alu ? ir[OPC_LO+2:OPC_LO] : ALU_NONE;
                    state  <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (cls.alu) begin
                        reg_wr_vld <= 1'b1;
                        state      <= ST_WB;
                    end else if (cls.ld || cls.st) begin
                        dm_rd <= cls.ld;
                        dm_wr <= cls.st;
                        state <= ST_MEM;
                    end else if (cls.halt) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        if (cls.jmp || (cls.bz && zero_flag)) begin
                            pc <= pc_imm;
                        end else begin
                            pc <= pc_inc;
                        end
                        illegal <= cls.illegal;
                        imem_rd <= 1'b1;
                        state   <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (cls.ld) begin
                        reg_wr_vld <= 1'b1;
                        load_op    <= 1'b1;
                        state      <= ST_WB;
                    end else begin
                        pc      <= pc_inc;
                        imem_rd <= 1'b1;
                        state   <= ST_FETCH;
                    end
                end
                ST_WB: begin
                    pc      <= pc_inc;
                    imem_rd <= 1'b1;
                    state   <= ST_FETCH;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    imem_rd <= 1'b1;
                    state   <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc_ctrl.sv
// Directed bench for risc_ctrl: one task per scenario with hand-computed
// expectations, plus a strobe-exclusivity monitor.
module tb_risc_ctrl;
    import risc_pkg::*;

    logic        clk;
    logic        rst;
    logic        imem_rd;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic        instr_vld;
    logic        zero_flag;
    logic [2:0]  opnda_addr;
    logic [2:0]  opndb_addr;
    logic [2:0]  dst;
    logic [2:0]  alu_op;
    logic        reg_wr_vld;
    logic        load_op;
    logic        dm_rd;
    logic        dm_wr;
    logic        halted;
    logic        illegal;
    state_e      state_dbg;

    int vectors;
    int miscompares;

    risc_ctrl #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_rd    (imem_rd),
        .pc         (pc),
        .instr      (instr),
        .instr_vld  (instr_vld),
        .zero_flag  (zero_flag),
        .opnda_addr (opnda_addr),
        .opndb_addr (opndb_addr),
        .dst        (dst),
        .alu_op     (alu_op),
        .reg_wr_vld (reg_wr_vld),
        .load_op    (load_op),
        .dm_rd      (dm_rd),
        .dm_wr      (dm_wr),
        .halted     (halted),
        .illegal    (illegal),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        instr_vld = 1'b0;
        zero_flag = 1'b0;
        instr     = 16'h0000;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Presents one instruction for a single FETCH cycle, then scrambles instr
    // so later decode stages cannot depend on the bus.
    task automatic issue(input logic [15:0] w);
        instr     = w;
        instr_vld = 1'b1;
        cyc();
        instr_vld = 1'b0;
        instr     = 16'($urandom_range(0, 65535));
    endtask

    // strobes are one-hot at most and confined to WB / MEM
    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            if (($countones({reg_wr_vld, dm_rd, dm_wr}) > 1) ||
                (reg_wr_vld && state_dbg != ST_WB) ||
                ((dm_rd || dm_wr) && state_dbg != ST_MEM)) begin
                miscompares++;
                $display("FAIL strobe_excl: state=%0d wr=%b rd=%b wrm=%b, required exclusive in WB/MEM",
                         state_dbg, reg_wr_vld, dm_rd, dm_wr);
            end
        end
    end

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({imem_rd, pc, state_dbg} !== {1'b1, 8'h00, ST_FETCH}) begin
            miscompares++;
            $display("FAIL reset_core: imem_rd=%b pc=%h state=%0d, required 1 00 0", imem_rd, pc, state_dbg);
        end
        vectors++;
        if ({reg_wr_vld, load_op, dm_rd, dm_wr, halted, illegal, dst, alu_op} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outs: got %h, required 000",
                     {reg_wr_vld, load_op, dm_rd, dm_wr, halted, illegal, dst, alu_op});
        end
    endtask

    task automatic test_alu();
        issue(16'h1408);
        vectors++;
        if ({state_dbg, opnda_addr, opndb_addr, dst, imem_rd} !== {ST_DECODE, 3'd0, 3'd1, 3'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL alu_decode: state=%0d a=%0d b=%0d d=%0d imem=%b, required 1 0 1 2 0",
                     state_dbg, opnda_addr, opndb_addr, dst, imem_rd);
        end
        cyc();
        vectors++;
        if ({alu_op, reg_wr_vld} !== {ALU_ADD, 1'b0}) begin
            miscompares++;
            $display("FAIL alu_exec: alu_op=%0d wr=%b, required 1 0", alu_op, reg_wr_vld);
        end
        cyc();
        vectors++;
        if ({reg_wr_vld, load_op, dst, pc} !== {1'b1, 1'b0, 3'd2, 8'h00}) begin
            miscompares++;
            $display("FAIL alu_wb: wr=%b ld=%b d=%0d pc=%h, required 1 0 2 00", reg_wr_vld, load_op, dst, pc);
        end
        cyc();
        vectors++;
        if ({state_dbg, imem_rd, reg_wr_vld, pc} !== {ST_FETCH, 1'b1, 1'b0, 8'h01}) begin
            miscompares++;
            $display("FAIL alu_next: state=%0d imem=%b wr=%b pc=%h, required 0 1 0 01",
                     state_dbg, imem_rd, reg_wr_vld, pc);
        end
    endtask

    task automatic test_ld();
        issue(16'h8AC0);
        vectors++;
        if ({opnda_addr, dst} !== {3'd3, 3'd5}) begin
            miscompares++;
            $display("FAIL ld_decode: a=%0d d=%0d, required 3 5", opnda_addr, dst);
        end
        cyc();
        cyc();
        vectors++;
        if ({state_dbg, dm_rd, dm_wr, reg_wr_vld} !== {ST_MEM, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL ld_mem: state=%0d rd=%b wr=%b rwr=%b, required 3 1 0 0",
                     state_dbg, dm_rd, dm_wr, reg_wr_vld);
        end
        cyc();
        vectors++;
        if ({dm_rd, reg_wr_vld, load_op, dst} !== {1'b0, 1'b1, 1'b1, 3'd5}) begin
            miscompares++;
            $display("FAIL ld_wb: rd=%b wr=%b ld=%b d=%0d, required 0 1 1 5", dm_rd, reg_wr_vld, load_op, dst);
        end
        cyc();
        vectors++;
        if ({state_dbg, load_op, pc} !== {ST_FETCH, 1'b0, 8'h02}) begin
            miscompares++;
            $display("FAIL ld_next: state=%0d ld=%b pc=%h, required 0 0 02", state_dbg, load_op, pc);
        end
    endtask

    task automatic test_st();
        issue(16'h9000);
        cyc();
        cyc();
        vectors++;
        if ({dm_wr, dm_rd, reg_wr_vld} !== 3'b100) begin
            miscompares++;
            $display("FAIL st_mem: wrm=%b rd=%b wr=%b, required 1 0 0", dm_wr, dm_rd, reg_wr_vld);
        end
        cyc();
        vectors++;
        if ({state_dbg, dm_wr, pc} !== {ST_FETCH, 1'b0, 8'h03}) begin
            miscompares++;
            $display("FAIL st_next: state=%0d wrm=%b pc=%h, required 0 0 03", state_dbg, dm_wr, pc);
        end
    endtask

    task automatic test_bz();
        zero_flag = 1'b0;
        issue(16'hB040);
        cyc();
        zero_flag = 1'b1;
        cyc();
        vectors++;
        if ({state_dbg, pc} !== {ST_FETCH, 8'h40}) begin
            miscompares++;
            $display("FAIL bz_taken: state=%0d pc=%h, required 0 40", state_dbg, pc);
        end
        // zero_flag high during DECODE only must not make the branch taken
        zero_flag = 1'b1;
        issue(16'hB010);
        cyc();
        zero_flag = 1'b0;
        cyc();
        vectors++;
        if ({state_dbg, pc} !== {ST_FETCH, 8'h41}) begin
            miscompares++;
            $display("FAIL bz_not_taken: state=%0d pc=%h, required 0 41", state_dbg, pc);
        end
    endtask

    task automatic test_wrap();
        issue(16'hA0FF);
        cyc();
        cyc();
        vectors++;
        if (pc !== 8'hFF) begin
            miscompares++;
            $display("FAIL jmp_ff: pc=%h, required ff", pc);
        end
        issue(16'h0000);
        cyc();
        cyc();
        vectors++;
        if ({state_dbg, pc} !== {ST_FETCH, 8'h00}) begin
            miscompares++;
            $display("FAIL inc_wrap: state=%0d pc=%h, required 0 00", state_dbg, pc);
        end
        issue(16'hA0FF);
        cyc();
        cyc();
        issue(16'hA000);
        cyc();
        cyc();
        vectors++;
        if (pc !== 8'h00) begin
            miscompares++;
            $display("FAIL jmp_from_ff: pc=%h, required 00", pc);
        end
    endtask

    task automatic test_stall();
        logic [7:0] pc0;
        pc0 = 8'h00;
        for (int i = 0; i < 3; i++) begin
            instr     = 16'($urandom_range(0, 65535));
            instr_vld = 1'b0;
            cyc();
            vectors++;
            if ({state_dbg, imem_rd, pc, reg_wr_vld, dm_rd, dm_wr} !== {ST_FETCH, 1'b1, pc0, 3'b000}) begin
                miscompares++;
                $display("FAIL stall_%0d: state=%0d imem=%b pc=%h strobes=%b%b%b, required 0 1 %h 000",
                         i, state_dbg, imem_rd, pc, reg_wr_vld, dm_rd, dm_wr, pc0);
            end
        end
    endtask

    task automatic test_illegal();
        issue(16'hD123);
        cyc();
        vectors++;
        if (illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL ill_early: illegal=%b, required 0", illegal);
        end
        cyc();
        vectors++;
        if ({illegal, state_dbg, pc, reg_wr_vld, dm_rd, dm_wr} !== {1'b1, ST_FETCH, 8'h01, 3'b000}) begin
            miscompares++;
            $display("FAIL ill_pulse: illegal=%b state=%0d pc=%h strobes=%b%b%b, required 1 0 01 000",
                     illegal, state_dbg, pc, reg_wr_vld, dm_rd, dm_wr);
        end
        cyc();
        vectors++;
        if (illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL ill_once: illegal=%b, required 0", illegal);
        end
    endtask

    task automatic test_halt();
        issue(16'hF000);
        cyc();
        cyc();
        vectors++;
        if ({halted, imem_rd, state_dbg} !== {1'b1, 1'b0, ST_HALT}) begin
            miscompares++;
            $display("FAIL halt_enter: halted=%b imem=%b state=%0d, required 1 0 5", halted, imem_rd, state_dbg);
        end
        instr     = 16'h1408;
        instr_vld = 1'b1;
        cyc();
        cyc();
        cyc();
        instr_vld = 1'b0;
        vectors++;
        if ({halted, imem_rd, state_dbg, pc, reg_wr_vld} !== {1'b1, 1'b0, ST_HALT, 8'h01, 1'b0}) begin
            miscompares++;
            $display("FAIL halt_hold: halted=%b imem=%b state=%0d pc=%h wr=%b, required 1 0 5 01 0",
                     halted, imem_rd, state_dbg, pc, reg_wr_vld);
        end
    endtask

    task automatic test_reset_mid_ld();
        do_reset();
        issue(16'h1408);
        cyc();
        cyc();
        cyc();
        issue(16'h8AC0);
        cyc();
        cyc();
        vectors++;
        if ({state_dbg, dm_rd} !== {ST_MEM, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_ld_setup: state=%0d rd=%b, required 3 1", state_dbg, dm_rd);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        vectors++;
        if ({state_dbg, pc, reg_wr_vld, dm_rd, load_op, imem_rd} !== {ST_FETCH, 8'h00, 4'b0001}) begin
            miscompares++;
            $display("FAIL mid_ld_reset: state=%0d pc=%h wr=%b rd=%b ld=%b imem=%b, required 0 00 0 0 0 1",
                     state_dbg, pc, reg_wr_vld, dm_rd, load_op, imem_rd);
        end
        cyc();
        vectors++;
        if ({state_dbg, reg_wr_vld, imem_rd, pc} !== {ST_FETCH, 1'b0, 1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL mid_ld_after: state=%0d wr=%b imem=%b pc=%h, required 0 0 1 00",
                     state_dbg, reg_wr_vld, imem_rd, pc);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        instr       = 16'h0000;
        instr_vld   = 1'b0;
        zero_flag   = 1'b0;
        test_reset();
        test_alu();
        test_ld();
        test_st();
        test_bz();
        test_wrap();
        test_stall();
        test_illegal();
        test_halt();
        test_reset_mid_ld();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
